// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM states, redirect-select codes, fetch constants.
package pc_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the decode/branch-compare logic and the PC sequencer.
interface pc_sequencer_if;

    logic        stall;
    logic        take_branch;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_pending;
    logic        illegal_ds;
    logic        addr_err;

    modport master (
        output stall, take_branch, branch_offset, jump, jump_index, jr, jr_target,
        input  pc, pc_plus4, redirect_pending, illegal_ds, addr_err
    );

    modport slave (
        input  stall, take_branch, branch_offset, jump, jump_index, jr, jr_target,
        output pc, pc_plus4, redirect_pending, illegal_ds, addr_err
    );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational redirect-target generator for branch, jump and register-jump forms.
module branch_target_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [15:0] offset_i,
    input  logic [25:0] index_i,
    input  logic [31:0] jr_target_i,
    input  sel_e        sel_i,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic signed [31:0] br_disp;

    // Word offset sign-extended and scaled to bytes; the sum wraps mod 2^32.
    assign br_disp = {{14{offset_i[15]}}, offset_i, 2'b00};

    always_comb begin
        target_o   = pc_plus4_i;
        misalign_o = 1'b0;
        case (sel_i)
            SEL_BR:  target_o = pc_plus4_i + $unsigned(br_disp);
            SEL_J:   target_o = {pc_plus4_i[31:28], index_i, 2'b00};
            SEL_JR: begin
                target_o   = {jr_target_i[31:2], 2'b00};
                misalign_o = |jr_target_i[1:0];
            end
            default: target_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch PC register with redirect priority and optional architectural delay slot.
// Define BRANCH_DELAY_SLOT_EN for the RUN/PENDING delay-slot FSM; otherwise redirects are immediate.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        misalign;
    sel_e        sel;

    assign pc_plus4     = pc_q + INSN_BYTES;
    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.addr_err = err_q;

    always_comb begin
        sel = SEL_SEQ;
        if (bus.jr)               sel = SEL_JR;
        else if (bus.jump)        sel = SEL_J;
        else if (bus.take_branch) sel = SEL_BR;
    end

    branch_target_calc u_target (
        .pc_plus4_i  (pc_plus4),
        .offset_i    (bus.branch_offset),
        .index_i     (bus.jump_index),
        .jr_target_i (bus.jr_target),
        .sel_i       (sel),
        .target_o    (target),
        .misalign_o  (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        illegal_q, illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            tgt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        err_d     = err_q;
        state_d   = state_q;
        tgt_d     = tgt_q;
        illegal_d = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    pc_d = pc_plus4;
                    if (sel != SEL_SEQ) begin
                        tgt_d   = target;
                        state_d = ST_PENDING;
                        err_d   = err_q | misalign;
                    end
                end
                ST_PENDING: begin
                    // Delay-slot instruction may not redirect; its request is dropped and flagged.
                    pc_d      = tgt_q;
                    state_d   = ST_RUN;
                    illegal_d = (sel != SEL_SEQ);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign bus.redirect_pending = (state_q == ST_PENDING);
    assign bus.illegal_ds       = illegal_q;
`else
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (!bus.stall) begin
            pc_d  = (sel != SEL_SEQ) ? target : pc_plus4;
            err_d = err_q | misalign;
        end
    end

    assign bus.redirect_pending = 1'b0;
    assign bus.illegal_ds       = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS datapath. It holds the fetch PC and advances it by 4 each cycle. It applies redirects for a taken branch (the branch-compare output `S`), a direct jump, or a register jump, and it supports pipeline stalls. It sits directly downstream of the branch comparator and replaces the stand-alone PC register and PC-source mux.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  freezes PC, state and flags this cycle; all redirect inputs are ignored.
- `take_branch`  in  1  taken-branch decision from the branch comparator for the instruction at `pc`.
- `branch_offset`  in  16  signed word offset (instruction imm16).
- `jump`  in  1  J/JAL at `pc`.
- `jump_index`  in  26  instruction index field.
- `jr`  in  1  JR/JALR at `pc`.
- `jr_target`  in  32  register value for JR.
- `pc`  out  32  current fetch address (registered).
- `pc_plus4`  out  32  `pc + 4` (combinational), for link writes.
- `redirect_pending`  out  1  high while a delay-slot target is held (registered state).
- `illegal_ds`  out  1  one-cycle pulse: redirect requested from inside a delay slot.
- `addr_err`  out  1  sticky: a JR target was misaligned.

## Operation
- Reset values: `pc`=RESET_PC, state RUN, held target=0, `redirect_pending`=0, `illegal_ds`=0, `addr_err`=0.
- Redirect priority: `jr` > `jump` > `take_branch`. Only the highest-priority asserted request is used.
- Target arithmetic, all mod 2^32 (wrap-around, no error):
  - Branch: `pc_plus4 + (sext32(branch_offset) << 2)`.
  - Jump: `{pc_plus4[31:28], jump_index, 2'b00}`.
  - JR: `{jr_target[31:2], 2'b00}`. If `jr_target[1:0]` != 0 the JR is still taken, and `addr_err` sets and stays set until `rst`.
- Sequential, non-stall cycle with no redirect: `pc` <= `pc_plus4`.
- Stall cycle: all registers hold. `illegal_ds` is 0. A request present during a stall is not remembered.
- FSM with delay slot (RUN, PENDING):
  - RUN + redirect: `pc` <= `pc_plus4`, target is latched, go to PENDING.
  - PENDING (no stall): `pc` <= held target, go to RUN. Any redirect request in this cycle is ignored and `illegal_ds` pulses.
- Without delay slot: the FSM is RUN only, and a redirect loads `pc` <= target directly.
- `rst` mid-PENDING: the held target is discarded and `pc`=RESET_PC.

## Timing
- Redirect inputs are combinational from the instruction at the current `pc` and are sampled at the next rising edge.
- Redirect latency: 1 edge without delay slot; with delay slot, 2 edges (one delay-slot fetch).
- `pc_plus4` has zero latency from `pc`. `redirect_pending` and `addr_err` are registered. `illegal_ds` is registered and asserted for exactly the cycle after the offending edge.
- Stall during PENDING extends PENDING by one cycle per stalled cycle. The target is preserved.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined: MIPS architectural delay slot; FSM RUN/PENDING as above; `illegal_ds` is live.
- Undefined: immediate redirect; `redirect_pending` and `illegal_ds` are tied 0; no target register is synthesized.

## Structure
- Shared package/header `pc_pkg` holds:
  - State encoding (RUN=0, PENDING=1).
  - `INSN_BYTES`=4 and default `RESET_PC`.
  - Redirect-select encoding (SEQ, BR, J, JR).
- One sub-module, `branch_target_calc`: combinational. Inputs are `pc_plus4`, offset, index, `jr_target` and the select. Outputs are the 32-bit target and the misalign flag.
- Registers, priority logic and FSM live in `pc_sequencer`.

## Test plan
- Reset then 3 free-running cycles -> `pc` = 0x0, 0x4, 0x8, 0xC; `redirect_pending`=0.
- At `pc`=0x100, `take_branch`=1, offset=0xFFFE -> target 0x0FC. With delay slot the next PCs are 0x104 then 0x0FC; without delay slot the next PC is 0x0FC.
- At `pc`=0xFFFFFFFC, no redirect -> `pc` wraps to 0x0. Branch offset 0x0001 at the same `pc` -> target 0x4.
- `jr`=1, `jump`=1, `take_branch`=1 together, `jr_target`=0x2003 -> `pc` reaches 0x2000 and `addr_err`=1, staying 1 until `rst`.
- Delay-slot build: branch at 0x40 to 0x80, `stall` for 2 cycles in PENDING, then `jump` asserted in the delay slot -> `pc` holds 0x44 for 2 cycles, then 0x80, and `illegal_ds` pulses once.
- `rst` asserted asynchronously while PENDING -> `pc`=RESET_PC immediately and `redirect_pending`=0; the next PC is RESET_PC+4.
